id_lexer: RTL

Parametrised streaming token recognizer for the CPU-project front end. Consumes one 8-bit ASCII character per accepted cycle and classifies runs of characters into identifier, number or malformed tokens. Emits one registered token report per run, with length and overflow status. Also keeps the legacy `out` level, which flags "letters followed by digits" on each accepted digit.

---
 rtl/id_lexer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/id_lexer.sv
// id_lexer: streaming token recognizer.
// Classifies runs of ASCII characters into identifier, number or malformed
// tokens and emits one registered report per run (type, saturated length,
// overflow). Also drives the legacy `out` level, which is high after a digit
// that continues an identifier.
module id_lexer #(
   parameter int MAX_LEN  = 16,
   parameter int LEN_W    = 5,
   parameter bit ALLOW_US = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       char,
   input  logic             in_valid,
   input  logic             flush,
   output logic             out,
   output logic             tok_valid,
   output logic [1:0]       tok_type,
   output logic [LEN_W-1:0] tok_len,
   output logic             tok_ovf
);

   // The counter is one bit wider than the reported length so it can hold
   // MAX_LEN+1, which marks "longer than reportable".
   localparam int CW = LEN_W + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);
   localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LEN + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [1:0] T_ID  = 2'b01;
   localparam logic [1:0] T_NUM = 2'b10;
   localparam logic [1:0] T_BAD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ID_L,
      S_ID_D,
      S_NUM,
      S_BAD
   } state_t;

   state_t          state;
   state_t          state_adv;   // after the current character, before flush
   state_t          state_nxt;   // after flush
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_inc;
   logic [CW-1:0]   cnt_adv;
   logic [CW-1:0]   cnt_nxt;

   logic            is_letter;
   logic            is_digit;

   logic            emit;
   state_t          emit_state;
   logic [CW-1:0]   emit_cnt;
   logic [1:0]      emit_type;
   logic [LEN_W-1:0] emit_len;
   logic            emit_ovf;
   logic            out_nxt;

   // Character classification.
   always_comb begin
      is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                  ((char >= 8'h61) && (char <= 8'h7A)) ||
                  (ALLOW_US && (char == 8'h5F));
      is_digit  = (char >= 8'h30) && (char <= 8'h39);
   end

   // Saturating length increment.
   always_comb begin
      cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
   end

   // Next state: apply the accepted character, then let flush close whatever
   // is still open. A separator already closes the token, so flush on the
   // same cycle finds S_IDLE and cannot produce a second report.
   always_comb begin
      // NOTE: every signal assigned here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_adv  = state;
      cnt_adv    = cnt;
      emit       = 1'b0;
      emit_state = state;
      emit_cnt   = cnt;
      out_nxt    = out;

      if (in_valid) begin
         out_nxt = 1'b0;
         unique case (state)
            S_IDLE: begin
               if (is_letter) begin
                  state_adv = S_ID_L;
                  cnt_adv   = CNT_ONE;
               end else if (is_digit) begin
                  state_adv = S_NUM;
                  cnt_adv   = CNT_ONE;
               end
            end
            S_ID_L, S_ID_D: begin
               if (is_letter) begin
                  state_adv = S_ID_L;
                  cnt_adv   = cnt_inc;
               end else if (is_digit) begin
                  state_adv = S_ID_D;
                  cnt_adv   = cnt_inc;
                  out_nxt   = 1'b1;
               end else begin
                  emit      = 1'b1;
                  state_adv = S_IDLE;
                  cnt_adv   = '0;
               end
            end
            S_NUM: begin
               if (is_digit) begin
                  cnt_adv   = cnt_inc;
               end else if (is_letter) begin
                  state_adv = S_BAD;
                  cnt_adv   = cnt_inc;
               end else begin
                  emit      = 1'b1;
                  state_adv = S_IDLE;
                  cnt_adv   = '0;
               end
            end
            S_BAD: begin
               if (is_letter || is_digit) begin
                  cnt_adv   = cnt_inc;
               end else begin
                  emit      = 1'b1;
                  state_adv = S_IDLE;
                  cnt_adv   = '0;
               end
            end
            default: begin
               state_adv = S_IDLE;
               cnt_adv   = '0;
            end
         endcase
      end

      state_nxt = state_adv;
      cnt_nxt   = cnt_adv;
      if (flush && (state_adv != S_IDLE)) begin
         emit       = 1'b1;
         emit_state = state_adv;
         emit_cnt   = cnt_adv;
         state_nxt  = S_IDLE;
         cnt_nxt    = '0;
      end
   end

   // Report fields for the token being closed this cycle.
   always_comb begin
      unique case (emit_state)
         S_ID_L, S_ID_D: emit_type = T_ID;
         S_NUM:          emit_type = T_NUM;
         S_BAD:          emit_type = T_BAD;
         default:        emit_type = 2'b00;
      endcase
      emit_ovf = (emit_cnt > CNT_MAX);
      emit_len = emit_ovf ? CNT_MAX[LEN_W-1:0] : emit_cnt[LEN_W-1:0];
   end

   // FSM state, length counter and legacy match level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         out   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out   <= out_nxt;
      end
   end

   // Token report registers; fields hold their last value between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_valid <= 1'b0;
         tok_type  <= 2'b00;
         tok_len   <= '0;
         tok_ovf   <= 1'b0;
      end else begin
         tok_valid <= emit;
         if (emit) begin
            tok_type <= emit_type;
            tok_len  <= emit_len;
            tok_ovf  <= emit_ovf;
         end
      end
   end

endmodule
